gauss_sample_fifo: RTL
======================

Name: gauss_sample_fifo

Overview:
- Downstream stage of the multi-hat Gaussian generator top level.
- Consumes the free-running 16-bit summed Gaussian sample that the adder stage produces every clock.
- Discards a fixed number of post-reset samples while the LFSR / hat_mul / adder pipeline fills.
- Buffers valid samples in a FIFO and presents them on a valid/ready stream; counts samples lost to overflow.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- WARMUP, 8, cycles after reset release whose samples are discarded; must be at least 1.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; samples are taken only while en=1.
- in_data  input  16  Gaussian sample from the adder stage, new value every cycle, two's complement, passed through unmodified.
- out_data  output  16  head-of-FIFO sample (first-word fall-through).
- out_valid  output  1  high when the FIFO is non-empty.
- out_ready  input  1  consumer accepts out_data on a rising edge when out_valid=1.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- warm  output  1  high once the WARMUP state has completed.
- drop_count  output  CNT_W  number of samples dropped because the FIFO was full; saturating.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=WARMUP, warm counter=0, rd/wr pointers=0, count=0, out_valid=0, full=0, warm=0, drop_count=0, out_data=16'h0000. Memory contents are don't-care.
- Reset asserted mid-operation discards all buffered data and restarts WARMUP. No partial push or pop completes on the reset edge.
- States:
  - WARMUP: counter increments every clock regardless of en. No push, no drop counting. After WARMUP rising edges go to RUN; warm=1 from that point.
  - RUN: remains in RUN until reset.
- Sample index: with in_data changing each cycle, the value present at the (WARMUP+1)-th rising edge after reset release is the first sample eligible for capture.
- Pop: out_valid && out_ready at a rising edge. rd_ptr advances, count decrements.
- Push attempt: state=RUN && en=1 at a rising edge.
  - Succeeds if count<DEPTH, or if count==DEPTH and a pop occurs on the same edge.
  - On success: in_data written at wr_ptr, wr_ptr advances.
- Drop: push attempt while count==DEPTH with no simultaneous pop. Sample discarded, drop_count increments, saturating at all-ones. Buffered data and pointers are unchanged.
- Occupancy on each edge: push only → +1; pop only → -1; both → unchanged.
- Empty FIFO: no pop is possible (out_valid=0), so a push to an empty FIFO never bypasses.
- Latency: a sample pushed into an empty FIFO appears on out_data with out_valid=1 one cycle after the push edge.
- out_data holds the head value while out_valid=1 and no pop occurs. When out_valid=0, out_data is don't-care but must not be X after reset.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Order is strictly FIFO across wrap.
- Outputs full, out_valid and count derive from registered state only; none are combinational paths from out_ready or en.
- Handshake: the consumer may hold out_ready high continuously. Deasserting out_ready never loses data.

Test Plan:
1. Warm-up discard: reset 2 cycles, then en=1, out_ready=0, in_data=0x0000,0x0001,… one per edge after release → warm rises after 8 edges; first out_data=0x0008 with out_valid=1; count=1 one cycle later.
2. Fill and overflow: continue scenario 1 with out_ready=0 for 20 RUN edges → count=16, full=1 after 16 pushes; drop_count=4; out_data stays 0x0008.
3. Full with simultaneous push/pop: from full, set out_ready=1, en=1 for 10 edges → count stays 16, drop_count stays 4; out_data steps 0x0008,0x0009,…,0x0011 in order with no gap; pointers wrap cleanly.
4. Drain: en=0, out_ready=1 → exactly 16 further samples delivered in order; out_valid falls the cycle after the last pop; count=0, full=0.
5. Reset mid-operation: with count=5, pulse reset between clock edges → out_valid, count, drop_count, warm go to 0 immediately, before the next edge; the next 8 samples after release are discarded.
6. Saturation: hold full with en=1, out_ready=0 for 70000 RUN edges → drop_count=16'hFFFF and remains there; no buffered data corrupted (drain reproduces the original 16 values).

Source files
------------

// File: rtl/gauss_sample_fifo.sv
// Output buffer for the multi-hat Gaussian generator: discards the pipeline-fill samples after
// reset, then queues samples in a first-word-fall-through FIFO with a saturating overflow-drop counter.
module gauss_sample_fifo #(
    parameter int DEPTH  = 16,
    parameter int WARMUP = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [15:0]              in_data,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     warm,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int DATA_W = 16;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int WW     = $clog2(WARMUP + 1);

    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic {
        S_WARMUP = 1'b0,
        S_RUN    = 1'b1
    } state_t;

    state_t                    state, state_nxt;
    logic        [WW-1:0]      warm_cnt, warm_cnt_nxt;
    logic        [PW-1:0]      rd_ptr, wr_ptr;
    logic        [CW-1:0]      count_r;
    logic        [CNT_W-1:0]   drop_r;
    logic signed [DATA_W-1:0]  mem [DEPTH];

    logic pop, push_try, push, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign out_valid  = (count_r != '0);
    assign full       = (count_r == FULL_CNT);
    assign count      = count_r;
    assign warm       = (state == S_RUN);
    assign drop_count = drop_r;

    // Memory is not reset, so mask the head while empty to keep out_data defined.
    assign out_data   = out_valid ? mem[rd_ptr] : '0;

    assign pop      = out_valid && out_ready;
    assign push_try = (state == S_RUN) && en;
    assign push     = push_try && (!full || pop);
    assign drop     = push_try && full && !pop;

    always_comb begin
        state_nxt    = state;
        warm_cnt_nxt = warm_cnt;
        case (state)
            S_WARMUP: begin
                warm_cnt_nxt = warm_cnt + WW'(1);
                if (warm_cnt == WARM_LAST)
                    state_nxt = S_RUN;
            end
            S_RUN: ;
            default: state_nxt = S_WARMUP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_WARMUP;
            warm_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_r  <= '0;
            drop_r   <= '0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= warm_cnt_nxt;
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop)
                drop_r <= sat_inc(drop_r);
        end
    end

    // push is forced low during reset because state is held in WARMUP.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

endmodule
